lcd_time_sched: RTL and testbench

LCD_TIME_SCHED -- requirements
Module: lcd_time_sched

---
 rtl/lcd_time_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_lcd_time_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_time_sched.sv
// lcd_time_sched: renders "HH:MM:SS" to an LCD character renderer, one glyph
// per request, with a per-glyph handshake timeout and a one-deep queue for
// time updates that arrive while a frame is being drawn.
//
// Build option: define LCD_TIME_DIFF_EN to redraw only the glyphs that changed
// since the last completed draw. Without it, every frame redraws all 8 positions.
//
// state | meaning
// IDLE  | waiting for init_done together with a new or queued time
// LATCH | capture the time, build the glyphs and the redraw mask
// ISSUE | one-cycle render request for the current position
// WAIT  | waiting for show_char_done or for the wait counter to expire
// NEXT  | step to the next position in the mask, or finish the frame
// DONE  | one-cycle frame_done pulse
module lcd_time_sched #(
    parameter logic [8:0]  X0      = 9'd16,
    parameter logic [8:0]  Y0      = 9'd40,
    parameter logic [8:0]  PITCH   = 9'd8,
    parameter logic        FONT16  = 1'b1,
    parameter logic [15:0] TIMEOUT = 16'd20000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       init_done,
    input  logic       time_valid,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       show_char_done,
    output logic       show_char_flag,
    output logic [6:0] ascii_num,
    output logic [8:0] start_x,
    output logic [8:0] start_y,
    output logic       en_size,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err
);

    typedef enum logic [2:0] {IDLE, LATCH, ISSUE, WAIT, NEXT, DONE} state_t;

    localparam logic [6:0]  COLON   = 7'd26;
    localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

    state_t           state, state_nxt;
    logic             pending;
    logic [4:0]       hour_s;
    logic [5:0]       min_s, sec_s;
    logic [6:0]       h_bcd, m_bcd, s_bcd;
    logic [7:0][6:0]  glyph_c, glyph_q;
    logic [7:0]       mask_c, mask_q;
    logic [2:0]       pos;
    logic [3:0]       sel;
    logic [8:0]       sel_x;
    logic [15:0]      wait_cnt;
    logic             wait_expired;

    // Repeated subtract of ten; six steps cover any 6-bit value. Returns {tens, units}.
    function automatic logic [6:0] to_bcd(input logic [5:0] v);
        logic [5:0] r;
        logic [2:0] t;
        r = v;
        t = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (r >= 6'd10) begin
                r = r - 6'd10;
                t = t + 3'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

    function automatic logic [6:0] dig(input logic [3:0] d);
        return 7'd16 + {3'b000, d};
    endfunction

    // Lowest set mask bit at or above 'from'; 8 means none left.
    function automatic logic [3:0] first_set(input logic [7:0] m, input logic [3:0] from);
        logic [3:0] r;
        r = 4'd8;
        for (int k = 7; k >= 0; k--) begin
            if (m[k] && (4'(k) >= from)) r = 4'(k);
        end
        return r;
    endfunction

    assign start_y      = Y0;
    assign en_size      = FONT16;
    assign wait_expired = (state == WAIT) && !show_char_done && (wait_cnt == TO_LAST);

    // Glyph indices for the shadowed time; hours 24-31 display as-is.
    always_comb begin
        h_bcd      = to_bcd({1'b0, hour_s});
        m_bcd      = to_bcd(min_s);
        s_bcd      = to_bcd(sec_s);
        glyph_c    = '0;
        glyph_c[0] = dig({1'b0, h_bcd[6:4]});
        glyph_c[1] = dig(h_bcd[3:0]);
        glyph_c[2] = COLON;
        glyph_c[3] = dig({1'b0, m_bcd[6:4]});
        glyph_c[4] = dig(m_bcd[3:0]);
        glyph_c[5] = COLON;
        glyph_c[6] = dig({1'b0, s_bcd[6:4]});
        glyph_c[7] = dig(s_bcd[3:0]);
    end

`ifdef LCD_TIME_DIFF_EN
    logic [7:0][6:0] last_q;
    logic [7:0]      last_vld;

    // Redraw only positions whose glyph differs from what is on screen.
    always_comb begin
        mask_c = '0;
        for (int i = 0; i < 8; i++) begin
            mask_c[i] = !last_vld[i] || (last_q[i] != glyph_c[i]);
        end
    end

    // Track what is on screen; a timed-out glyph is treated as unknown.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_q   <= '0;
            last_vld <= '0;
        end else if (state == WAIT) begin
            if (show_char_done) begin
                last_q[pos]   <= glyph_q[pos];
                last_vld[pos] <= 1'b1;
            end else if (wait_expired) begin
                last_vld[pos] <= 1'b0;
            end
        end
    end
`else
    // Full redraw every frame.
    always_comb begin
        mask_c = 8'hFF;
    end
`endif

    // Next position to draw: from the fresh mask in LATCH, otherwise after pos.
    always_comb begin
        if (state == LATCH) sel = first_set(mask_c, 4'd0);
        else                sel = first_set(mask_q, {1'b0, pos} + 4'd1);
        sel_x = X0 + 9'(sel[2:0]) * PITCH;
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt      = state;
        show_char_flag = 1'b0;
        busy           = 1'b1;
        frame_done     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (init_done && (time_valid || pending)) state_nxt = LATCH;
            end
            LATCH:   state_nxt = sel[3] ? DONE : ISSUE;
            ISSUE: begin
                show_char_flag = 1'b1;
                state_nxt      = WAIT;
            end
            WAIT:    if (show_char_done || wait_expired) state_nxt = NEXT;
            NEXT:    state_nxt = sel[3] ? DONE : ISSUE;
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Time shadow/queue, frame contents, glyph outputs, wait counter, error flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pending     <= 1'b0;
            hour_s      <= '0;
            min_s       <= '0;
            sec_s       <= '0;
            glyph_q     <= '0;
            mask_q      <= '0;
            pos         <= '0;
            ascii_num   <= '0;
            start_x     <= X0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (time_valid) begin
                hour_s <= hour;
                min_s  <= min;
                sec_s  <= sec;
            end
            // A strobe consumed straight from IDLE needs no queue entry.
            if (time_valid && !(state == IDLE && init_done)) pending <= 1'b1;
            else if (state == LATCH)                          pending <= 1'b0;

            if (state == LATCH) begin
                glyph_q <= glyph_c;
                mask_q  <= mask_c;
            end
            if ((state == LATCH || state == NEXT) && !sel[3]) begin
                pos       <= sel[2:0];
                ascii_num <= (state == LATCH) ? glyph_c[sel[2:0]] : glyph_q[sel[2:0]];
                start_x   <= sel_x;
            end

            if (state == ISSUE)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;

            if (wait_expired) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_time_sched.sv
// Directed bench for lcd_time_sched: table of times with hand-computed glyph
// sequences, plus sequences for queueing, timeout, late init and mid-frame reset.
module tb_lcd_time_sched;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       init_done = 1'b0;
    logic       time_valid = 1'b0;
    logic [4:0] hour = '0;
    logic [5:0] min = '0;
    logic [5:0] sec = '0;
    logic       resp_done;
    logic       stray_done = 1'b0;
    logic       show_char_done;
    logic       show_char_flag;
    logic [6:0] ascii_num;
    logic [8:0] start_x;
    logic [8:0] start_y;
    logic       en_size;
    logic       busy;
    logic       frame_done;
    logic       timeout_err;

    assign show_char_done = resp_done | stray_done;

    lcd_time_sched #(
        .X0(9'd16), .Y0(9'd40), .PITCH(9'd8), .FONT16(1'b1), .TIMEOUT(16'd100)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
        .time_valid(time_valid), .hour(hour), .min(min), .sec(sec),
        .show_char_done(show_char_done), .show_char_flag(show_char_flag),
        .ascii_num(ascii_num), .start_x(start_x), .start_y(start_y),
        .en_size(en_size), .busy(busy), .frame_done(frame_done),
        .timeout_err(timeout_err)
    );

    initial forever #5 sys_clk = ~sys_clk;

    localparam logic [71:0] X_EXP = {9'd16, 9'd24, 9'd32, 9'd40, 9'd48, 9'd56, 9'd64, 9'd72};

    int         n_chk = 0;
    int         n_fail = 0;
    int         nflag = 0;
    int         nframe = 0;
    int         stab_err = 0;
    logic [6:0] log_a [128];
    logic [8:0] log_x [128];
    logic [8:0] suppress_x = 9'h1FF;

    // Log every render request and frame completion.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (show_char_flag === 1'b1) begin
                if (nflag < 128) begin
                    log_a[nflag] = ascii_num;
                    log_x[nflag] = start_x;
                end
                nflag++;
            end
            if (frame_done === 1'b1) nframe++;
        end
    end

    // Renderer model: done 30 cycles after each flag, except at suppress_x.
    initial begin
        int         cnt;
        logic [6:0] cap_a;
        logic [8:0] cap_x;
        cnt = 0;
        cap_a = '0;
        cap_x = '0;
        resp_done = 1'b0;
        forever begin
            @(negedge sys_clk);
            resp_done = 1'b0;
            if (!sys_rst_n) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    resp_done = 1'b1;
                    if (ascii_num !== cap_a || start_x !== cap_x) stab_err++;
                end
            end else if (show_char_flag === 1'b1 && start_x !== suppress_x) begin
                cnt = 30;
                cap_a = ascii_num;
                cap_x = start_x;
            end
        end
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        sys_rst_n  = 1'b0;
        time_valid = 1'b0;
        stray_done = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_tv(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        hour = h;
        min = m;
        sec = s;
        time_valid = 1'b1;
        tick();
        time_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (nframe < target && n < 3000) begin
            tick();
            n++;
        end
        check("frame_reached", 72'(nframe >= target), 72'd1);
        tick();
    endtask

    task automatic wait_flags(input int target);
        int n;
        n = 0;
        while (nflag < target && n < 3000) begin
            tick();
            n++;
        end
        check("flag_reached", 72'(nflag >= target), 72'd1);
    endtask

    function automatic logic [71:0] pack_a(input int base, input int n);
        logic [71:0] r;
        r = '0;
        for (int k = 0; k < n; k++) if (base + k < 128) r = {r[64:0], log_a[base + k]};
        return r;
    endfunction

    function automatic logic [71:0] pack_x(input int base, input int n);
        logic [71:0] r;
        r = '0;
        for (int k = 0; k < n; k++) if (base + k < 128) r = {r[62:0], log_x[base + k]};
        return r;
    endfunction

    typedef struct {
        logic [4:0]  h;
        logic [5:0]  m;
        logic [5:0]  s;
        logic [55:0] exp_g;
    } vec_t;

    vec_t vecs [5];
    int   gb, fb;

    initial begin
        vecs[0] = '{5'd12, 6'd34, 6'd56, {7'd17, 7'd18, 7'd26, 7'd19, 7'd20, 7'd26, 7'd21, 7'd22}};
        vecs[1] = '{5'd0,  6'd0,  6'd0,  {7'd16, 7'd16, 7'd26, 7'd16, 7'd16, 7'd26, 7'd16, 7'd16}};
        vecs[2] = '{5'd23, 6'd59, 6'd59, {7'd18, 7'd19, 7'd26, 7'd21, 7'd25, 7'd26, 7'd21, 7'd25}};
        vecs[3] = '{5'd31, 6'd9,  6'd10, {7'd19, 7'd17, 7'd26, 7'd16, 7'd25, 7'd26, 7'd17, 7'd16}};
        vecs[4] = '{5'd9,  6'd45, 6'd7,  {7'd16, 7'd25, 7'd26, 7'd20, 7'd21, 7'd26, 7'd16, 7'd23}};

        // Reset values
        do_reset();
        check("rst_flag",    72'(show_char_flag), 72'd0);
        check("rst_busy",    72'(busy),           72'd0);
        check("rst_fdone",   72'(frame_done),     72'd0);
        check("rst_terr",    72'(timeout_err),    72'd0);
        check("rst_ascii",   72'(ascii_num),      72'd0);
        check("rst_x",       72'(start_x),        72'd16);
        check("rst_y",       72'(start_y),        72'd40);
        check("rst_en_size", 72'(en_size),        72'd1);

        // Table: one full frame per time value
        for (int i = 0; i < 5; i++) begin
            do_reset();
            init_done = 1'b1;
            gb = nflag;
            fb = nframe;
            pulse_tv(vecs[i].h, vecs[i].m, vecs[i].s);
            wait_frames(fb + 1);
            check("tbl_flags",  72'(nflag - gb),  72'd8);
            check("tbl_glyphs", pack_a(gb, 8),    72'(vecs[i].exp_g));
            check("tbl_xpos",   pack_x(gb, 8),    X_EXP);
            check("tbl_frames", 72'(nframe - fb), 72'd1);
            check("tbl_idle",   72'(busy),        72'd0);
        end

        // Back-to-back strobes while busy: only the latest is drawn
        do_reset();
        init_done = 1'b1;
        gb = nflag;
        fb = nframe;
        pulse_tv(5'd12, 6'd34, 6'd56);
        repeat (40) tick();
        check("q_busy", 72'(busy), 72'd1);
        pulse_tv(5'd0, 6'd0, 6'd1);
        repeat (20) tick();
        pulse_tv(5'd0, 6'd0, 6'd2);
        repeat (20) tick();
        pulse_tv(5'd0, 6'd0, 6'd3);
        wait_frames(fb + 2);
        repeat (600) tick();
        check("q_frames", 72'(nframe - fb), 72'd2);
`ifdef LCD_TIME_DIFF_EN
        check("q_flags",  72'(nflag - gb),  72'd14);
        check("q_glyphs", pack_a(gb + 8, 6), 72'({7'd16, 7'd16, 7'd16, 7'd16, 7'd16, 7'd19}));
`else
        check("q_flags",  72'(nflag - gb),  72'd16);
        check("q_glyphs", pack_a(gb + 8, 8),
              72'({7'd16, 7'd16, 7'd26, 7'd16, 7'd16, 7'd26, 7'd16, 7'd19}));
`endif

        // Timeout at position 2
        do_reset();
        gb = nflag;
        fb = nframe;
        suppress_x = 9'd32;
        pulse_tv(5'd12, 6'd34, 6'd56);
        wait_flags(gb + 3);
        repeat (90) tick();
        check("to_early", 72'(timeout_err), 72'd0);
        repeat (20) tick();
        check("to_set",   72'(timeout_err), 72'd1);
        check("to_pos3",  72'(nflag - gb),  72'd4);
        check("to_pos3x", 72'(log_x[gb + 3]), 72'd40);
        wait_frames(fb + 1);
        suppress_x = 9'h1FF;
        check("to_flags", 72'(nflag - gb), 72'd8);
        check("to_sticky", 72'(timeout_err), 72'd1);

        // Time arrives before init_done; frame starts when init_done rises
        do_reset();
        init_done = 1'b0;
        gb = nflag;
        fb = nframe;
        pulse_tv(5'd23, 6'd59, 6'd59);
        repeat (20) tick();
        check("init_hold_busy",  72'(busy),       72'd0);
        check("init_hold_flags", 72'(nflag - gb), 72'd0);
        init_done = 1'b1;
        tick();
        check("init_start", 72'(busy), 72'd1);
        repeat (50) tick();
        init_done = 1'b0;
        wait_frames(fb + 1);
        check("init_flags",  72'(nflag - gb), 72'd8);
        check("init_glyphs", pack_a(gb, 8),
              72'({7'd18, 7'd19, 7'd26, 7'd21, 7'd25, 7'd26, 7'd21, 7'd25}));

        // Stray done while idle does nothing
        gb = nflag;
        init_done = 1'b1;
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        repeat (5) tick();
        check("stray_busy",  72'(busy),       72'd0);
        check("stray_flags", 72'(nflag - gb), 72'd0);

        // Reset during WAIT at position 4
        do_reset();
        gb = nflag;
        fb = nframe;
        pulse_tv(5'd12, 6'd34, 6'd56);
        wait_flags(gb + 5);
        repeat (5) tick();
        sys_rst_n = 1'b0;
        tick();
        check("mr_busy",  72'(busy),           72'd0);
        check("mr_flag",  72'(show_char_flag), 72'd0);
        check("mr_ascii", 72'(ascii_num),      72'd0);
        check("mr_x",     72'(start_x),        72'd16);
        sys_rst_n = 1'b1;
        repeat (100) tick();
        check("mr_quiet",  72'(nflag - gb),  72'd5);
        check("mr_nofd",   72'(nframe - fb), 72'd0);
        pulse_tv(5'd0, 6'd0, 6'd0);
        wait_frames(fb + 1);
        check("mr_redraw", 72'(nflag - gb), 72'd13);
        check("mr_glyphs", pack_a(gb + 5, 8),
              72'({7'd16, 7'd16, 7'd26, 7'd16, 7'd16, 7'd26, 7'd16, 7'd16}));

        // Consecutive frames differing only in the last digit
        do_reset();
        gb = nflag;
        fb = nframe;
        pulse_tv(5'd12, 6'd34, 6'd56);
        wait_frames(fb + 1);
        gb = nflag;
        pulse_tv(5'd12, 6'd34, 6'd57);
        wait_frames(fb + 2);
`ifdef LCD_TIME_DIFF_EN
        check("diff_flags", 72'(nflag - gb),  72'd1);
        check("diff_ascii", 72'(log_a[gb]),   72'd23);
        check("diff_x",     72'(log_x[gb]),   72'd72);
`else
        check("full_flags", 72'(nflag - gb),  72'd8);
        check("full_last",  72'(log_a[gb + 7]), 72'd23);
        check("full_x",     pack_x(gb, 8),    X_EXP);
`endif

        check("glyph_stable", 72'(stab_err), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
